// File: rtl/mod_step_accum_pkg.sv
// Shared types and helpers for the multi-channel modular step/accumulate unit.
package mod_step_accum_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_ACC   = 2'd1,
    MODE_LOAD  = 2'd2,
    MODE_CLEAR = 2'd3
  } mode_t;

  // Index width that stays at least one bit even for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mod_step_accum_add.sv
// Combinational a + b reduced mod MODULUS; both addends must already be < MODULUS.
module mod_add_reduce #(
  parameter int WIDTH   = 7,
  parameter int MODULUS = 100
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum_mod,
  output logic             wrap
);

  localparam logic [WIDTH:0] MOD_W = (WIDTH+1)'(MODULUS);

  logic [WIDTH:0] w_sum;

  // The extra sum bit lets MODULUS == 2**WIDTH work without a special case.
  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign wrap    = (w_sum >= MOD_W);
  assign sum_mod = wrap ? WIDTH'(w_sum - MOD_W) : w_sum[WIDTH-1:0];

endmodule

// File: rtl/mod_step_accum.sv
// Multi-channel modular increment / accumulator with a registered valid/ready output.
module mod_step_accum
  import mod_step_accum_pkg::*;
#(
  parameter  int WIDTH    = 7,
  parameter  int MODULUS  = 100,
  parameter  int STEP     = 1,
  parameter  int CHANNELS = 4,
  localparam int CW       = clog2_min1(CHANNELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW-1:0]    in_chan,
  input  logic [1:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_chan,
  output logic [WIDTH-1:0] out_data,
  output logic             out_wrap
);

  if (MODULUS < 2) begin : g_chk_mod_min
    $error("MODULUS must be at least 2");
  end
  if (64'(MODULUS) > (64'(1) << WIDTH)) begin : g_chk_mod_max
    $error("MODULUS must not exceed 2**WIDTH");
  end
  if (STEP < 0 || STEP >= MODULUS) begin : g_chk_step
    $error("STEP must lie in [0, MODULUS)");
  end
  if (CHANNELS < 1) begin : g_chk_chan
    $error("CHANNELS must be at least 1");
  end

  localparam logic [WIDTH:0]   MOD_W  = (WIDTH+1)'(MODULUS);
  localparam logic [CW:0]      CHN_W  = (CW+1)'(CHANNELS);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] r_acc [CHANNELS];
  logic             r_out_valid;
  logic [CW-1:0]    r_out_chan;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_wrap;

  mode_t            w_mode;
  logic [CW-1:0]    w_chan;
  logic             w_accept;
  logic [WIDTH-1:0] w_op;
  logic             w_op_big;
  logic [WIDTH-1:0] w_acc_cur;
  logic [WIDTH-1:0] w_add_a;
  logic [WIDTH-1:0] w_add_b;
  logic [WIDTH-1:0] w_sum_mod;
  logic             w_add_wrap;
  logic [WIDTH-1:0] w_res;
  logic             w_res_wrap;

  assign w_mode    = mode_t'(in_mode);
  assign w_chan    = ({1'b0, in_chan} < CHN_W) ? in_chan : '0;
  assign in_ready  = (!r_out_valid || out_ready) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign w_op      = WIDTH'({1'b0, in_data} % MOD_W);
  assign w_op_big  = ({1'b0, in_data} >= MOD_W);
  assign w_acc_cur = r_acc[w_chan];

  mod_add_reduce #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_add (
    .a       (w_add_a),
    .b       (w_add_b),
    .sum_mod (w_sum_mod),
    .wrap    (w_add_wrap)
  );

  // One adder serves both PASS (op + STEP) and ACC (acc + op).
  always_comb begin
    w_add_a    = w_op;
    w_add_b    = STEP_W;
    w_res      = '0;
    w_res_wrap = 1'b0;
    if (w_mode == MODE_ACC) begin
      w_add_a = w_acc_cur;
      w_add_b = w_op;
    end
    case (w_mode)
      MODE_PASS, MODE_ACC: begin
        w_res      = w_sum_mod;
        w_res_wrap = w_add_wrap;
      end
      MODE_LOAD: begin
        w_res      = w_op;
        w_res_wrap = w_op_big;
      end
      default: begin
        w_res      = '0;
        w_res_wrap = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_acc[i] <= '0;
      end
    end else if (w_accept) begin
      case (w_mode)
        MODE_ACC:   r_acc[w_chan] <= w_sum_mod;
        MODE_LOAD:  r_acc[w_chan] <= w_op;
        MODE_CLEAR: r_acc[w_chan] <= '0;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_out_data  <= '0;
      r_out_wrap  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_chan  <= w_chan;
      r_out_data  <= w_res;
      r_out_wrap  <= w_res_wrap;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;
  assign out_data  = r_out_data;
  assign out_wrap  = r_out_wrap;

endmodule
